byte_data_memory: RTL and testbench
===================================

BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 1024; number of DATA_W words, power of two, >= 2.
REQ-002 SHALL have parameter DATA_W, default 32; word width in bits, fixed at 32 in this generation.
REQ-003 SHALL have localparam ADDR_W = log2(DEPTH)+2; byte-address width.
REQ-004 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_req  input  1  access request, sampled when o_ready=1.
REQ-007 SHALL have port i_we  input  1  1=store, 0=load.
REQ-008 SHALL have port i_addr  input  ADDR_W  byte address; word index = i_addr[ADDR_W-1:2], lane = i_addr[1:0].
REQ-009 SHALL have port i_funct3  input  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port i_wdata  input  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port o_ready  output  1  block in IDLE and able to accept a request.
REQ-012 SHALL have port o_rvalid  output  1  one-cycle pulse, load result valid.
REQ-013 SHALL have port o_rdata  output  DATA_W  load result, extended per i_funct3.
REQ-014 SHALL have port o_misalign  output  1  one-cycle pulse, rejected access.

Function
REQ-015 SHALL implement FSM states INIT and IDLE; reset enters INIT with clear counter = 0.
REQ-016 SHALL, in INIT, write zero to word[counter] each cycle, increment counter, and enter IDLE after the cycle that clears word DEPTH-1 (DEPTH cycles total).
REQ-017 SHALL drive o_ready=0 in INIT, 1 in IDLE; i_req in INIT is ignored, no queuing.
REQ-018 SHALL accept a request when i_req=1 and o_ready=1 (same edge).
REQ-019 SHALL, on accepted aligned store, update only the addressed lanes that cycle: SB one lane = i_wdata[7:0]; SH lanes {1,0} or {3,2} = i_wdata[15:0]; SW all lanes.
REQ-020 SHALL, on accepted aligned load, present o_rdata and o_rvalid=1 exactly one cycle after acceptance (registered read, latency 1).
REQ-021 SHALL sign-extend for B/H, zero-extend for BU/HU, and pass W unchanged.
REQ-022 SHALL treat as misaligned: H/HU with i_addr[0]=1; W with i_addr[1:0]!=0; any funct3 of 011, 110, 111; store with funct3 100 or 101.
REQ-023 SHALL, on a misaligned access, leave memory unchanged and pulse o_misalign one cycle after acceptance; a misaligned load also pulses o_rvalid with o_rdata=0.
REQ-024 SHALL let a load accepted on the cycle after a store to the same word return the stored data.
REQ-025 SHALL hold o_rdata at its last value between loads; o_rvalid and o_misalign are 0 when not pulsing.
REQ-026 SHALL sustain one accepted request per cycle in IDLE.

Reset
REQ-027 SHALL, on i_rst, immediately force o_ready=0, o_rvalid=0, o_misalign=0, o_rdata=0, state=INIT, counter=0.
REQ-028 SHALL, when reset is asserted mid-operation, drop any pending load result or misalign pulse and restart the full INIT sweep.
REQ-029 SHALL leave memory array contents unreset by i_rst; zeroing is done only by the INIT sweep.

Structure
REQ-030 SHALL take funct3 encodings and the FSM state enum from shared package mem_pkg.
REQ-031 SHALL place lane-mask generation and load extraction/extension in one combinational sub-module, mem_lane_align.
REQ-032 SHALL model storage as byte-lane-writable so it maps to block RAM with byte enables.

Verification
REQ-033 SHALL cover: DEPTH=16, release reset -> o_ready=0 for 16 cycles then 1; every word reads 0x00000000.
REQ-034 SHALL cover: SW 0x80FF7F01 @0x4, then LB @0x4 -> 0x00000001, LB @0x7 -> 0xFFFFFF80, LBU @0x7 -> 0x00000080, LH @0x6 -> 0xFFFF80FF.
REQ-035 SHALL cover: SB 0xAA @0x9 over word 0x11223344 @0x8, then LW @0x8 -> 0x1122AA44, with o_rvalid exactly 1 cycle after each load.
REQ-036 SHALL cover: SW @0x2 and LH @0x3 -> o_misalign pulses; word 0 unchanged; LH returns o_rvalid with o_rdata=0.
REQ-037 SHALL cover: i_rst asserted the cycle after LW acceptance -> no o_rvalid, o_ready=0, and a full INIT sweep re-zeroes memory.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressable data memory.
// Contents: the word width, the RV32I load/store size codes (funct3), and the
// controller state enum.
package mem_pkg;

  localparam int unsigned WordW = 32;

  // RV32I load/store size codes
  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3BU = 3'b100;
  localparam logic [2:0] Funct3HU = 3'b101;

  typedef enum logic {
    StInit,
    StIdle
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for byte, half-word and word accesses.
// Store side:
//   we, addr_lo, funct3, wdata -> byte_en, wdata_lane, misalign
// Load side:
//   rd_word, rd_lane, rd_funct3 -> rd_data (sign- or zero-extended)
// misalign flags size/alignment violations and funct3 codes that are
// illegal for the access direction.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic             we,
  input  logic [1:0]       addr_lo,
  input  logic [2:0]       funct3,
  input  logic [WordW-1:0] wdata,
  output logic [3:0]       byte_en,
  output logic [WordW-1:0] wdata_lane,
  output logic             misalign,
  input  logic [WordW-1:0] rd_word,
  input  logic [1:0]       rd_lane,
  input  logic [2:0]       rd_funct3,
  output logic [WordW-1:0] rd_data
);

  // Request decode: lane mask, replicated write data, alignment check
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = '0;
    misalign   = 1'b0;
    case (funct3)
      Funct3B, Funct3BU: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        // Unsigned variants exist only for loads
        misalign   = we && (funct3 == Funct3BU);
      end
      Funct3H, Funct3HU: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        misalign   = addr_lo[0] || (we && (funct3 == Funct3HU));
      end
      Funct3W: begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
        misalign   = (addr_lo != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

  // Load extraction from the registered word
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte = rd_word[8*rd_lane +: 8];
    rd_half = rd_lane[1] ? rd_word[31:16] : rd_word[15:0];
    rd_data = rd_word;
    case (rd_funct3)
      Funct3B:  rd_data = {{24{rd_byte[7]}}, rd_byte};
      Funct3BU: rd_data = {24'h0, rd_byte};
      Funct3H:  rd_data = {{16{rd_half[15]}}, rd_half};
      Funct3HU: rd_data = {16'h0, rd_half};
      default:  rd_data = rd_word;
    endcase
  end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable single-port data memory for an RV32I core.
// After reset it sweeps every word to zero (INIT), then accepts one load or
// store per cycle (IDLE). Loads return one cycle after acceptance.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_req, i_we            request strobe, 1 = store / 0 = load
//   i_addr, i_funct3       byte address, RV32I size code
//   i_wdata                right-aligned store data
//   o_ready                idle and able to accept a request
//   o_rvalid, o_rdata      load result pulse and extended data
//   o_misalign             pulse for a rejected access
module byte_data_memory
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_funct3,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ready,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_misalign
);

  localparam int unsigned IdxW = ADDR_W - 2;

  // Controller
  state_e          state_q, state_d;
  logic [IdxW-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IdxW'(DEPTH - 1)) state_d = StIdle;
      end
      StIdle:  state_d = StIdle;
      default: state_d = StInit;
    endcase
  end

  assign o_ready = (state_q == StIdle);

  logic            accept;
  logic [IdxW-1:0] idx;

  assign accept = i_req && o_ready;
  assign idx    = i_addr[ADDR_W-1:2];

  // Lane steering
  logic [3:0]       byte_en;
  logic [WordW-1:0] wdata_lane;
  logic             misalign;
  logic [WordW-1:0] rd_word_q;
  logic [1:0]       rd_lane_q;
  logic [2:0]       rd_funct3_q;
  logic [WordW-1:0] rd_ext;

  mem_lane_align u_lane_align (
    .we         (i_we),
    .addr_lo    (i_addr[1:0]),
    .funct3     (i_funct3),
    .wdata      (i_wdata),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .misalign   (misalign),
    .rd_word    (rd_word_q),
    .rd_lane    (rd_lane_q),
    .rd_funct3  (rd_funct3_q),
    .rd_data    (rd_ext)
  );

  // Write port shared by the INIT sweep and accepted stores
  logic [3:0]       wr_be;
  logic [IdxW-1:0]  wr_idx;
  logic [WordW-1:0] wr_word;
  logic             rd_en;

  always_comb begin
    wr_be   = 4'b0000;
    wr_idx  = idx;
    wr_word = wdata_lane;
    if (state_q == StInit) begin
      wr_be   = 4'b1111;
      wr_idx  = cnt_q;
      wr_word = '0;
    end else if (accept && i_we && !misalign) begin
      wr_be = byte_en;
    end
  end

  assign rd_en = accept && !i_we && !misalign;

  // Storage: no reset so it maps onto block RAM with byte enables
  logic [3:0][7:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) mem_q[wr_idx][i] <= wr_word[8*i +: 8];
    end
    if (rd_en) rd_word_q <= mem_q[idx];
  end

  // Response registers. rd_zero_q forces o_rdata to 0 after reset and after a
  // misaligned load; rd_word_q only changes on loads so o_rdata holds.
  logic rvalid_q, mis_q, rd_zero_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rvalid_q    <= 1'b0;
      mis_q       <= 1'b0;
      rd_zero_q   <= 1'b1;
      rd_lane_q   <= 2'b00;
      rd_funct3_q <= Funct3W;
    end else begin
      rvalid_q <= accept && !i_we;
      mis_q    <= accept && misalign;
      if (accept && !i_we) begin
        rd_zero_q   <= misalign;
        rd_lane_q   <= i_addr[1:0];
        rd_funct3_q <= i_funct3;
      end
    end
  end

  assign o_rvalid   = rvalid_q;
  assign o_misalign = mis_q;
  assign o_rdata    = rd_zero_q ? '0 : DATA_W'(rd_ext);

endmodule

// File: tb/tb_byte_data_memory.sv
// Directed self-checking bench for byte_data_memory (DEPTH = 16).
module tb_byte_data_memory;

  localparam int unsigned Depth = 16;
  localparam int unsigned AddrW = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             req;
  logic             we;
  logic [AddrW-1:0] addr;
  logic [2:0]       funct3;
  logic [31:0]      wdata;
  logic             ready;
  logic             rvalid;
  logic [31:0]      rdata;
  logic             misalign;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  byte_data_memory #(
    .DEPTH  (Depth),
    .DATA_W (32)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_we       (we),
    .i_addr     (addr),
    .i_funct3   (funct3),
    .i_wdata    (wdata),
    .o_ready    (ready),
    .o_rvalid   (rvalid),
    .o_rdata    (rdata),
    .o_misalign (misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one rising edge; sample point is 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From the release of reset, count cycles with ready low (bounded)
  task automatic wait_init(input string tag);
    int lo = 0;
    while (!ready && lo < 100) begin
      lo++;
      tick();
    end
    check(tag, 32'(lo), 32'd16);
  endtask

  task automatic store(input logic [5:0] a, input logic [2:0] f3, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; funct3 = f3; wdata = d;
    tick();
    req = 1'b0;
  endtask

  // Load; checks latency-1 response, then that rvalid falls the next cycle
  task automatic load(input string tag, input logic [5:0] a, input logic [2:0] f3,
                      input logic [31:0] exp, input logic exp_mis);
    req = 1'b1; we = 1'b0; addr = a; funct3 = f3; wdata = '0;
    tick();
    req = 1'b0;
    check({tag, ".rvalid"}, 32'(rvalid), 32'd1);
    check({tag, ".data"}, rdata, exp);
    check({tag, ".mis"}, 32'(misalign), 32'(exp_mis));
    tick();
    check({tag, ".rvalid_drop"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; funct3 = 3'b010; wdata = '0;
    tick();
    tick();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mis", 32'(misalign), 32'd0);

    // Release reset mid-cycle, then expect exactly 16 not-ready cycles
    rst = 1'b0;
    req = 1'b1; // ignored during INIT
    wait_init("init_len");
    req = 1'b0;
    check("ready_up", 32'(ready), 32'd1);
    for (int w = 0; w < Depth; w++) load($sformatf("zero%0d", w), 6'(w * 4), 3'b010, 32'h0, 1'b0);

    // Sign/zero extension
    store(6'h04, 3'b010, 32'h80FF7F01);
    load("lb4",  6'h04, 3'b000, 32'h00000001, 1'b0);
    load("lb7",  6'h07, 3'b000, 32'hFFFFFF80, 1'b0);
    load("lbu7", 6'h07, 3'b100, 32'h00000080, 1'b0);
    load("lh6",  6'h06, 3'b001, 32'hFFFF80FF, 1'b0);
    load("lhu4", 6'h04, 3'b101, 32'h00007F01, 1'b0);
    load("lb6",  6'h06, 3'b000, 32'hFFFFFFFF, 1'b0);
    load("lw4",  6'h04, 3'b010, 32'h80FF7F01, 1'b0);

    // Partial stores
    store(6'h08, 3'b010, 32'h11223344);
    store(6'h09, 3'b000, 32'hFFFFFFAA);
    load("sb_lw8", 6'h08, 3'b010, 32'h1122AA44, 1'b0);
    store(6'h0A, 3'b001, 32'h1234BEEF);
    load("sh_lw8", 6'h08, 3'b010, 32'hBEEFAA44, 1'b0);

    // Hold between loads
    tick();
    tick();
    check("hold", rdata, 32'hBEEFAA44);

    // Back-to-back store then load of the same word
    req = 1'b1; we = 1'b1; addr = 6'h0C; funct3 = 3'b010; wdata = 32'hCAFEF00D;
    tick();
    check("b2b_st_rvalid", 32'(rvalid), 32'd0);
    we = 1'b0; wdata = '0;
    tick();
    req = 1'b0;
    check("b2b_rvalid", 32'(rvalid), 32'd1);
    check("b2b_data", rdata, 32'hCAFEF00D);

    // Misaligned and illegal accesses
    store(6'h02, 3'b010, 32'hDEADBEEF);
    check("sw2_mis", 32'(misalign), 32'd1);
    check("sw2_rvalid", 32'(rvalid), 32'd0);
    tick();
    check("sw2_mis_drop", 32'(misalign), 32'd0);
    load("lh3", 6'h03, 3'b001, 32'h0, 1'b1);
    check("lh3_hold0", rdata, 32'h0);
    store(6'h00, 3'b100, 32'h000000FF);
    check("sbu_mis", 32'(misalign), 32'd1);
    load("f3_011", 6'h00, 3'b011, 32'h0, 1'b1);
    load("w0_intact", 6'h00, 3'b010, 32'h0, 1'b0);

    // Reset right after a load is accepted
    req = 1'b1; we = 1'b0; addr = 6'h08; funct3 = 3'b010;
    @(posedge clk);
    rst = 1'b1;
    req = 1'b0;
    #1;
    check("rst_mid_rvalid", 32'(rvalid), 32'd0);
    check("rst_mid_ready", 32'(ready), 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    wait_init("reinit_len");
    load("rez8", 6'h08, 3'b010, 32'h0, 1'b0);
    load("rez4", 6'h04, 3'b010, 32'h0, 1'b0);
    load("rezC", 6'h0C, 3'b010, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
